// File: rtl/l1_line_fill_responder_if.sv
// Signal bundle between the L1 icache line-fill port, the responder and word-wide memory.
// The responder is the slave; the icache/memory side (or a testbench) is the master.
interface l1_line_fill_responder_if;
    logic         l1_read;
    logic [15:0]  l1_address;
    logic         l1_resp;
    logic [127:0] l1_rdata;
    logic         inval;
    logic         mem_read;
    logic [15:0]  mem_address;
    logic         mem_resp;
    logic [15:0]  mem_rdata;

    modport slave (
        input  l1_read, l1_address, inval, mem_resp, mem_rdata,
        output l1_resp, l1_rdata, mem_read, mem_address
    );

    modport master (
        output l1_read, l1_address, inval, mem_resp, mem_rdata,
        input  l1_resp, l1_rdata, mem_read, mem_address
    );
endinterface

// File: rtl/l1_line_fill_responder.sv
// Fills one 128-bit icache line from eight 16-bit memory reads and returns it in one cycle.
// A single-line buffer answers repeated requests for the same line without touching memory.
module l1_line_fill_responder (
    input  logic                     clk,
    input  logic                     reset_n,
    l1_line_fill_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FILL, RESPOND} state_t;

    state_t        state;
    logic [127:0]  line;
    logic [11:0]   buf_tag;
    logic          buf_valid;
    logic [11:0]   req_line;
    logic [2:0]    cnt;
    logic          fill_killed;
    logic          l1_resp_q;
    logic          mem_read_q;

    assign bus.l1_resp     = l1_resp_q;
    assign bus.l1_rdata    = line;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_address = {req_line, cnt, 1'b0};

    // NOTE: the line register is reset as well, because a reset mid-fill must not
    // leave partial data visible on l1_rdata.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            line        <= '0;
            buf_tag     <= '0;
            buf_valid   <= 1'b0;
            req_line    <= '0;
            cnt         <= '0;
            fill_killed <= 1'b0;
            l1_resp_q   <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            l1_resp_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.l1_read) begin
                        if (buf_valid && buf_tag == bus.l1_address[15:4]) begin
                            state     <= RESPOND;
                            l1_resp_q <= 1'b1;
                        end else begin
                            req_line    <= bus.l1_address[15:4];
                            cnt         <= '0;
                            fill_killed <= 1'b0;
                            mem_read_q  <= 1'b1;
                            state       <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (bus.inval) begin
                        fill_killed <= 1'b1;
                    end
                    if (bus.mem_resp) begin
                        line[{cnt, 4'b0000} +: 16] <= bus.mem_rdata;
                        if (cnt == 3'd7) begin
                            buf_tag    <= req_line;
                            buf_valid  <= !fill_killed;
                            mem_read_q <= 1'b0;
                            l1_resp_q  <= 1'b1;
                            state      <= RESPOND;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    mem_read_q <= 1'b0;
                end
            endcase
            // Invalidate wins over a fill completing in the same cycle.
            if (bus.inval) begin
                buf_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_l1_line_fill_responder.sv
// Directed-plus-random bench for l1_line_fill_responder with a line-level reference model
// and a word-wide memory model that can add random per-word latency.
module tb_l1_line_fill_responder;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    l1_line_fill_responder_if bus ();

    l1_line_fill_responder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Memory contents: word at byte address a is a ^ salt.
    logic [15:0] salt = 16'h0000;
    int          mem_max_delay = 0;
    bit          spurious = 1'b0;
    logic [15:0] fetch_q[$];

    // Reference model of the one-line buffer.
    bit           m_valid = 1'b0;
    logic [11:0]  m_tag   = '0;
    logic [127:0] m_line  = '0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ salt;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: answers the visible address after a random number of idle cycles.
    initial begin
        int wait_cnt;
        wait_cnt      = 0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_resp = 1'b0;
            if (bus.mem_read === 1'b1) begin
                if (wait_cnt == 0) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_address);
                    fetch_q.push_back(bus.mem_address);
                    wait_cnt = int'($urandom_range(mem_max_delay));
                end else begin
                    wait_cnt--;
                end
            end else if (spurious) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = 16'hDEAD;
            end
        end
    end

    task automatic do_request(input logic [15:0] addr, input int inval_at, input int switch_at,
                              input int reset_at, input string tag);
        logic [127:0] exp_line;
        logic [127:0] obs_seq;
        logic [127:0] exp_seq;
        logic [15:0]  base;
        bit           exp_hit;
        bit           killed;
        bit           done;
        int           cyc;

        base     = {addr[15:4], 4'h0};
        exp_hit  = m_valid && (m_tag == addr[15:4]);
        exp_line = m_line;
        exp_seq  = '0;
        if (!exp_hit) begin
            for (int i = 0; i < 8; i++) begin
                exp_line[16*i +: 16] = mem_word(base + 16'(2 * i));
                exp_seq[16*i +: 16]  = base + 16'(2 * i);
            end
        end
        fetch_q.delete();
        killed = 1'b0;
        done   = 1'b0;
        cyc    = 1;
        bus.l1_read    = 1'b1;
        bus.l1_address = addr;

        while (!done && cyc < 400) begin
            @(posedge clk);
            #2;
            cyc++;
            bus.inval = 1'b0;
            if (bus.l1_resp === 1'b1) begin
                done = 1'b1;
            end else begin
                if (reset_at >= 0 && fetch_q.size() == reset_at) begin
                    reset_n = 1'b0;
                    #1;
                    check({tag, "_rst_mem_read"}, bus.mem_read, 1'b0);
                    check({tag, "_rst_l1_resp"}, bus.l1_resp, 1'b0);
                    check({tag, "_rst_rdata"}, bus.l1_rdata, '0);
                    m_valid = 1'b0;
                    m_tag   = '0;
                    m_line  = '0;
                    bus.l1_read = 1'b0;
                    @(posedge clk);
                    #2;
                    reset_n = 1'b1;
                    @(posedge clk);
                    #2;
                    return;
                end
                if (inval_at >= 0 && fetch_q.size() == inval_at && !killed) begin
                    bus.inval = 1'b1;
                    killed    = 1'b1;
                end
                if (switch_at >= 0 && fetch_q.size() == switch_at) begin
                    bus.l1_address = 16'h8000;
                end
            end
        end

        check({tag, "_resp_seen"}, done, 1'b1);
        check({tag, "_rdata"}, bus.l1_rdata, exp_line);
        check({tag, "_fetch_count"}, fetch_q.size(), exp_hit ? 0 : 8);
        obs_seq = '0;
        for (int i = 0; i < fetch_q.size() && i < 8; i++) begin
            obs_seq[16*i +: 16] = fetch_q[i];
        end
        check({tag, "_fetch_addrs"}, obs_seq, exp_seq);
        if (mem_max_delay == 0) begin
            check({tag, "_latency"}, cyc, exp_hit ? 2 : 10);
        end

        bus.l1_read = 1'b0;
        bus.inval   = 1'b0;
        @(posedge clk);
        #2;
        check({tag, "_resp_single"}, bus.l1_resp, 1'b0);
        check({tag, "_mem_idle"}, bus.mem_read, 1'b0);

        if (!exp_hit) begin
            m_line  = exp_line;
            m_tag   = addr[15:4];
            m_valid = !killed;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] lines [4];
        lines[0] = 16'h5000;
        lines[1] = 16'h5012;
        lines[2] = 16'h5678;
        lines[3] = 16'h5A0E;

        reset_n        = 1'b0;
        bus.l1_read    = 1'b0;
        bus.l1_address = '0;
        bus.inval      = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_l1_resp", bus.l1_resp, 1'b0);
        check("reset_rdata", bus.l1_rdata, '0);
        check("reset_mem_read", bus.mem_read, 1'b0);
        check("reset_mem_address", bus.mem_address, '0);
        reset_n = 1'b1;
        @(posedge clk);
        #2;

        // Cold miss with data equal to byte address, then a hit in the same line.
        salt = 16'h0000;
        do_request(16'h1236, -1, -1, -1, "cold_miss");
        check("cold_line_const", bus.l1_rdata,
              128'h123E_123C_123A_1238_1236_1234_1232_1230);
        do_request(16'h123A, -1, -1, -1, "buffer_hit");
        check("hit_line_const", bus.l1_rdata,
              128'h123E_123C_123A_1238_1236_1234_1232_1230);

        // Invalidate during the 4th word: line still returned, next request refetches.
        salt = 16'h5A5A;
        do_request(16'h4000, 4, -1, -1, "inval_mid_fill");
        do_request(16'h4000, -1, -1, -1, "inval_refetch");

        // Invalidate together with the final word: buffer must stay invalid.
        salt = 16'h0F0F;
        do_request(16'h4000, 8, -1, -1, "inval_last_word");
        do_request(16'h4004, -1, -1, -1, "inval_last_refetch");

        // Stray mem_resp while idle must not disturb the buffer.
        spurious = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        spurious = 1'b0;
        check("spurious_rdata", bus.l1_rdata, m_line);
        do_request(16'h400C, -1, -1, -1, "spurious_hit");

        // Variable memory latency with the request address changed mid-fill.
        mem_max_delay = 5;
        salt = 16'(($urandom));
        do_request(16'h7654, -1, 2, -1, "var_lat_switch");
        for (int r = 0; r < 8; r++) begin
            int inv;
            inv  = (($urandom_range(3) == 0) ? int'($urandom_range(8, 1)) : -1);
            salt = 16'(($urandom));
            do_request(lines[$urandom_range(3)], inv, -1, -1, "random_req");
        end
        mem_max_delay = 0;

        // Reset after three words have been captured, then the same line must miss.
        salt = 16'h3C3C;
        do_request(16'h2220, -1, -1, 4, "reset_mid_fill");
        do_request(16'h2220, -1, -1, -1, "reset_refetch");

        // Tag aliasing: same low address bits, different line.
        salt = 16'h0000;
        do_request(16'h0010, -1, -1, -1, "alias_first");
        do_request(16'h1010, -1, -1, -1, "alias_second");
        check("alias_line_const", bus.l1_rdata,
              128'h101E_101C_101A_1018_1016_1014_1012_1010);

        // Invalidate while idle forces a refetch of the buffered line.
        bus.inval = 1'b1;
        @(posedge clk);
        #2;
        bus.inval = 1'b0;
        m_valid   = 1'b0;
        do_request(16'h1010, -1, -1, -1, "idle_inval_refetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/l1_line_fill_responder.md
# l1_line_fill_responder

Serves 128-bit line-fill reads from the L1 instruction cache by fetching eight consecutive 16-bit words from word-wide physical memory. It assembles them into one line and returns the line with a single-cycle response. It sits between the icache's L2-side port and the memory port. A one-line buffer answers repeated fetches of the same line without touching memory.

## Interface
- Parameters: none. Line geometry is fixed at 8 × 16-bit words, matching the L1 line type. Word i occupies bits [16i+15:16i].
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- l1_read  in  1  line request (level); held by the icache until l1_resp
- l1_address  in  16  byte address of requested fetch; bits [15:4] select the line
- l1_resp  out  1  one-cycle pulse: l1_rdata holds the requested line
- l1_rdata  out  128  line buffer contents
- inval  in  1  one-cycle pulse: invalidate line buffer
- mem_read  out  1  memory word-read request (level)
- mem_address  out  16  byte address of current word; bit 0 always 0
- mem_resp  in  1  one-cycle pulse: mem_rdata valid for current mem_address
- mem_rdata  in  16  memory read data

## Operation
- State: line register (128 b), buf_tag (12 b), buf_valid, req_line (12 b), word counter cnt (3 b), FSM {IDLE, FILL, RESPOND}.
- IDLE, l1_read=0: stay.
- IDLE, l1_read=1, buf_valid=1 and buf_tag==l1_address[15:4]:
  - hit → RESPOND.
- IDLE, l1_read=1, otherwise:
  - miss: req_line <= l1_address[15:4], cnt <= 0 → FILL.
- FILL:
  - mem_read=1, mem_address={req_line, cnt, 1'b0}.
  - On mem_resp: line[16*cnt+:16] <= mem_rdata.
  - If cnt==7: buf_tag <= req_line, buf_valid <= 1 → RESPOND.
  - Else cnt <= cnt+1; mem_read stays high with the next address.
- RESPOND: l1_resp=1 for exactly one cycle → IDLE.
- The icache deasserts l1_read the cycle after l1_resp. A still-high l1_read in IDLE is treated as a new request.
- l1_address changes during FILL or RESPOND are ignored, because req_line is latched.
- mem_resp outside FILL is ignored.
- inval in any state clears buf_valid.
  - If inval arrives during FILL, or in the same cycle as the final mem_resp, the fill completes and the line is returned.
  - In that case buf_valid remains 0.
- mem_address outside FILL holds {req_line, cnt, 1'b0} with mem_read=0. Memory must not act on it.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE.
  - buf_valid=0, buf_tag=0, req_line=0, cnt=0, line=0.
  - l1_resp=0, l1_rdata=0, mem_read=0, mem_address=0.
- Reset mid-FILL aborts the fill. mem_read drops without waiting for a clock. Partial data is discarded; line=0.
- Hit latency: l1_read sampled high in IDLE at edge N → l1_resp high during cycle N+1.
- Miss latency: l1_resp high the cycle after the edge that captures the 8th mem_resp.
  - With memory responding 1 cycle after each address, l1_read→l1_resp = 1 + 8×1 + 1 = 10 cycles.
- mem_address advances on the edge capturing mem_resp. The next word's request is visible the following cycle.
- l1_rdata is stable from the start of RESPOND until the next FILL writes lane 0.
- l1_resp, mem_read and mem_address are decoded from registered state and counter. There are no combinational paths from inputs to outputs.

## Test plan
- Cold miss:
  - Stimulus: after reset, l1_read=1, l1_address=0x1236; memory returns word value = byte address.
  - mem_address sequence must be 0x1230, 0x1232, …, 0x123E.
  - l1_rdata must equal 0x123E_123C_…_1232_1230.
  - l1_resp must be a single pulse, 10 cycles after the request with 1-cycle memory.
- Buffer hit: a second request to 0x123A right after the cold miss must produce l1_resp on the next cycle, with mem_read never asserted and identical l1_rdata.
- Invalidate mid-fill:
  - Pulse inval during the 4th word of a fill to 0x4000.
  - The line must still be returned.
  - A repeat request to 0x4000 must perform a new 8-word fill.
- Variable memory latency and address change:
  - Memory delays 0–5 random cycles per word.
  - l1_address is switched to 0x8000 mid-fill.
  - The fill must complete for the original line. No extra or lost words; mem_resp while idle must be ignored.
- Reset mid-fill: assert reset_n=0 after 3 words. mem_read, l1_resp and buf_valid must immediately be 0. A repeat request after reset must miss and refetch all 8 words.
- Tag aliasing: fill 0x0010, then request 0x1010 (same low bits, different line). Must miss and refetch, returning 0x1010-region data.
